// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
package hazard_unit_pkg;

  localparam int unsigned NREG_W = 4;
  localparam logic [NREG_W-1:0] ZERO_REG = 4'h0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hu_state_e;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use and ID-branch interlocks, taken-branch
// squash, data-memory freeze, plus saturating stall/flush counters.
module hazard_unit #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NREG_W = hazard_unit_pkg::NREG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREG_W-1:0] IF_ID_Rs,
  input  logic [NREG_W-1:0] IF_ID_Rt,
  input  logic              IF_ID_usesRs,
  input  logic              IF_ID_usesRt,
  input  logic              IF_ID_branch,
  input  logic              branch_taken,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic [NREG_W-1:0] ID_EX_dst_reg,
  input  logic              EX_MEM_MemRead,
  input  logic [NREG_W-1:0] EX_MEM_dst_reg,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              mem_wb_flush,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  import hazard_unit_pkg::*;

  hu_state_e state_q, state_d;
  logic      freeze, data_stall;
  logic      match_ex, match_mem;
  logic      load_use, br_on_alu, br_on_load;

  function automatic logic src_match(input logic [NREG_W-1:0] rs, input logic [NREG_W-1:0] rt,
                                     input logic use_rs, input logic use_rt,
                                     input logic [NREG_W-1:0] x);
    return (x != NREG_W'(ZERO_REG)) && ((use_rs && (rs == x)) || (use_rt && (rt == x)));
  endfunction

  assign match_ex  = src_match(IF_ID_Rs, IF_ID_Rt, IF_ID_usesRs, IF_ID_usesRt, ID_EX_dst_reg);
  assign match_mem = src_match(IF_ID_Rs, IF_ID_Rt, IF_ID_usesRs, IF_ID_usesRt, EX_MEM_dst_reg);

  assign load_use   = ID_EX_MemRead & ID_EX_RegWrite & match_ex;
  assign br_on_alu  = IF_ID_branch & ID_EX_RegWrite & ~ID_EX_MemRead & match_ex;
  assign br_on_load = IF_ID_branch & EX_MEM_MemRead & match_mem;

  // Freeze condition is identical in RUN and MEM_WAIT; state only records the wait.
  assign freeze     = ~rst & dmem_req & ~dmem_ready;
  assign data_stall = ~rst & ~freeze & (load_use | br_on_alu | br_on_load);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    state_d      = state_q;

    if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (data_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!rst && IF_ID_branch && branch_taken) begin
      if_id_flush = 1'b1;
    end

    case (state_q)
      RUN:      if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (~pc_write),
    .cnt_o (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (if_id_flush),
    .cnt_o (flush_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic
// compared every cycle against a rule-level model.
module tb_hazard_unit;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned NREG_W = 4;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_write,
  //                       id_ex_flush, ex_mem_write, mem_wb_flush}
  localparam logic [6:0] V_DEF    = 7'b1101010;
  localparam logic [6:0] V_FREEZE = 7'b0000001;
  localparam logic [6:0] V_STALL  = 7'b0001110;
  localparam logic [6:0] V_SQUASH = 7'b1111010;

  logic clk = 1'b0;
  logic rst;
  logic [NREG_W-1:0] IF_ID_Rs, IF_ID_Rt, ID_EX_dst_reg, EX_MEM_dst_reg;
  logic IF_ID_usesRs, IF_ID_usesRt, IF_ID_branch, branch_taken;
  logic ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead, dmem_req, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int mdl_stall = 0;
  int mdl_flush = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W), .NREG_W(NREG_W)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_usesRs(IF_ID_usesRs), .IF_ID_usesRt(IF_ID_usesRt),
    .IF_ID_branch(IF_ID_branch), .branch_taken(branch_taken),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_dst_reg(ID_EX_dst_reg),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_dst_reg(EX_MEM_dst_reg),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  function automatic logic [6:0] dut_vec();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush};
  endfunction

  function automatic bit reads(input logic [NREG_W-1:0] x);
    if (x == 0) return 1'b0;
    return (IF_ID_usesRs && IF_ID_Rs == x) || (IF_ID_usesRt && IF_ID_Rt == x);
  endfunction

  // Rule-level expectation: priority reset > memory freeze > interlock > squash.
  function automatic logic [6:0] model_vec();
    bit hazard;
    if (rst) return V_DEF;
    if (dmem_req && !dmem_ready) return V_FREEZE;
    hazard = (ID_EX_MemRead && ID_EX_RegWrite && reads(ID_EX_dst_reg))
          || (IF_ID_branch && ID_EX_RegWrite && !ID_EX_MemRead && reads(ID_EX_dst_reg))
          || (IF_ID_branch && EX_MEM_MemRead && reads(EX_MEM_dst_reg));
    if (hazard) return V_STALL;
    if (IF_ID_branch && branch_taken) return V_SQUASH;
    return V_DEF;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; counters observed mid-cycle reflect prior edges.
  initial begin
    logic [6:0] ev;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        ev = model_vec();
        chk("enables", int'(dut_vec()), int'(ev));
        chk("stall_cycles", int'(stall_cycles), mdl_stall);
        chk("flush_count", int'(flush_count), mdl_flush);
        if (rst) begin
          mdl_stall = 0;
          mdl_flush = 0;
        end else begin
          if (!ev[6] && mdl_stall < CMAX) mdl_stall++;
          if (ev[4] && mdl_flush < CMAX) mdl_flush++;
        end
      end
    end
  end

  task automatic idle();
    IF_ID_Rs = '0; IF_ID_Rt = '0; IF_ID_usesRs = 0; IF_ID_usesRt = 0;
    IF_ID_branch = 0; branch_taken = 0;
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_dst_reg = '0;
    EX_MEM_MemRead = 0; EX_MEM_dst_reg = '0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    step(); rst = 1; idle();
    step(); rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    @(posedge clk); #1;
    cmp_en = 1'b1;
    // Hazard inputs present during reset must not affect enables.
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_dst_reg = 4'd3;
    IF_ID_usesRs = 1; IF_ID_Rs = 4'd3; dmem_req = 1;
    sample(); chk("reset_enables", int'(dut_vec()), int'(V_DEF));
    step(); rst = 0; idle();
    sample(); chk("reset_stall_cnt", int'(stall_cycles), 0);
    chk("reset_flush_cnt", int'(flush_count), 0);

    // Load-use on R3.
    step(); ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_dst_reg = 4'd3;
    IF_ID_usesRs = 1; IF_ID_Rs = 4'd3;
    sample(); chk("load_use", int'(dut_vec()), int'(V_STALL));
    step(); idle();
    sample(); chk("load_use_after", int'(dut_vec()), int'(V_DEF));
    chk("load_use_cnt", int'(stall_cycles), 1);

    // Load to R0 is never a hazard.
    step(); ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_dst_reg = 4'd0;
    IF_ID_usesRs = 1; IF_ID_Rs = 4'd0; IF_ID_usesRt = 1;
    sample(); chk("r0_no_stall", int'(dut_vec()), int'(V_DEF));

    // Branch on R5 after ALU op: one stall.
    do_reset();
    IF_ID_branch = 1; IF_ID_usesRt = 1; IF_ID_Rt = 4'd5;
    ID_EX_RegWrite = 1; ID_EX_dst_reg = 4'd5;
    sample(); chk("br_alu", int'(dut_vec()), int'(V_STALL));
    step(); ID_EX_RegWrite = 0;
    sample(); chk("br_alu_after", int'(dut_vec()), int'(V_DEF));

    // Branch on R5 after load: EX match then MEM match.
    do_reset();
    IF_ID_branch = 1; IF_ID_usesRs = 1; IF_ID_Rs = 4'd5;
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_dst_reg = 4'd5; branch_taken = 1;
    sample(); chk("br_load_1", int'(dut_vec()), int'(V_STALL));
    step(); ID_EX_MemRead = 0; ID_EX_RegWrite = 0; EX_MEM_MemRead = 1; EX_MEM_dst_reg = 4'd5;
    sample(); chk("br_load_2", int'(dut_vec()), int'(V_STALL));
    step(); EX_MEM_MemRead = 0; branch_taken = 0;
    sample(); chk("br_load_cnt", int'(stall_cycles), 2);
    chk("br_load_no_flush", int'(flush_count), 0);

    // Taken branch without hazard squashes once.
    step(); branch_taken = 1;
    sample(); chk("squash", int'(dut_vec()), int'(V_SQUASH));
    step(); IF_ID_branch = 0; branch_taken = 0;
    sample(); chk("squash_cnt", int'(flush_count), 1);

    // Memory freeze for 3 cycles, then release with defaults.
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("freeze", int'(dut_vec()), int'(V_FREEZE));
      step();
    end
    dmem_ready = 1;
    sample(); chk("release", int'(dut_vec()), int'(V_DEF));
    chk("freeze_cnt", int'(stall_cycles), 3);

    // Load-use hidden by freeze, appears on release.
    step(); dmem_ready = 0; ID_EX_MemRead = 1; ID_EX_RegWrite = 1;
    ID_EX_dst_reg = 4'd7; IF_ID_usesRt = 1; IF_ID_Rt = 4'd7;
    sample(); chk("freeze_over_lu", int'(dut_vec()), int'(V_FREEZE));
    step(); dmem_ready = 1;
    sample(); chk("release_lu", int'(dut_vec()), int'(V_STALL));

    // Reset while waiting on memory.
    step(); idle(); dmem_req = 1;
    step(); rst = 1;
    sample(); chk("rst_in_wait", int'(dut_vec()), int'(V_DEF));
    step(); rst = 0; idle();
    sample(); chk("after_rst_en", int'(dut_vec()), int'(V_DEF));
    chk("after_rst_cnt", int'(stall_cycles), 0);

    // Saturation of the stall counter.
    do_reset();
    dmem_req = 1;
    repeat (CMAX + 8) step();
    sample(); chk("stall_sat", int'(stall_cycles), CMAX);

    // Randomised traffic; small register range keeps hazards frequent.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      step();
      rst            = ($urandom_range(0, 59) == 0);
      IF_ID_Rs       = NREG_W'($urandom_range(0, 3));
      IF_ID_Rt       = NREG_W'($urandom_range(0, 3));
      IF_ID_usesRs   = 1'($urandom);
      IF_ID_usesRt   = 1'($urandom);
      IF_ID_branch   = 1'($urandom);
      branch_taken   = 1'($urandom);
      ID_EX_MemRead  = ($urandom_range(0, 2) == 0);
      ID_EX_RegWrite = 1'($urandom);
      ID_EX_dst_reg  = NREG_W'($urandom_range(0, 3));
      EX_MEM_MemRead = ($urandom_range(0, 2) == 0);
      EX_MEM_dst_reg = NREG_W'($urandom_range(0, 3));
      dmem_req       = ($urandom_range(0, 3) == 0);
      dmem_ready     = 1'($urandom);
    end
    step(); idle(); rst = 0;
    sample();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
